shadow_stack_unit: RTL and testbench

Hardware shadow stack that sits directly upstream of the commit stage. It records return addresses pushed by committing calls and checks return targets on committing returns. On a mismatch, overflow or underflow it raises a software-check exception, which feeds the commit stage's `ss_popchk_ex` input. Storage is an on-chip LIFO of `DEPTH` entries. There is no spill to memory; exhaustion is reported as a fault.

---
 rtl/shadow_stack_unit_pkg.sv | 32 +++
 rtl/ss_stack_ram.sv | 27 ++
 rtl/shadow_stack_unit.sv | 147 ++++++++++++++
 tb/tb_shadow_stack_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/shadow_stack_unit_pkg.sv
// Shared types for the shadow stack: exception record, fault codes and FSM states.
package shadow_stack_unit_pkg;

  localparam int unsigned VLEN     = 64;
  localparam int unsigned XLEN     = 64;
  localparam int unsigned SS_DEPTH = 16;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef enum logic [2:0] {
    SS_NONE     = 3'd0,
    SS_MISMATCH = 3'd3,
    SS_OVF      = 3'd4,
    SS_UNF      = 3'd5
  } ss_fault_e;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StFault
  } ss_state_e;

  // Fault code as it appears in exception_t.tval.
  function automatic logic [XLEN-1:0] ss_tval(ss_fault_e code);
    return {{(XLEN - 3){1'b0}}, code};
  endfunction

endpackage

// File: rtl/ss_stack_ram.sv
// Return-address storage: synchronous write, asynchronous read.
module ss_stack_ram
  import shadow_stack_unit_pkg::*;
#(
  parameter int unsigned DEPTH = SS_DEPTH,
  parameter int unsigned WIDTH = VLEN,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/shadow_stack_unit.sv
// Hardware shadow stack: records call return addresses and checks return targets at commit.
module shadow_stack_unit
  import shadow_stack_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = SS_DEPTH,
  parameter int unsigned SS_CAUSE = 18,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            flush_i,
  input  logic            push_valid_i,
  input  logic [VLEN-1:0] push_addr_i,
  output logic            push_ready_o,
  input  logic            popchk_valid_i,
  input  logic [VLEN-1:0] popchk_addr_i,
  output logic            popchk_ready_o,
  output logic            done_o,
  output exception_t      ss_popchk_ex_o,
  input  logic            ex_ack_i,
  output logic [CW-1:0]   count_o
);

  ss_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [VLEN-1:0] top_q, top_d;
  logic [VLEN-1:0] tgt_q, tgt_d;
  ss_fault_e       code_q, code_d;
  logic            done_q, done_d;

  logic            mem_we;
  logic [VLEN-1:0] mem_top;
  logic [CW-1:0]   cnt_p1, cnt_m1;
  logic            cnt_full, cnt_empty;
  logic            push_acc, pop_acc;

  assign cnt_p1    = cnt_q + CW'(1);
  assign cnt_m1    = cnt_q - CW'(1);
  assign cnt_full  = (cnt_q == CW'(DEPTH));
  assign cnt_empty = (cnt_q == '0);

  // A flush in the accepting cycle drops the request outright.
  assign pop_acc  = (state_q == StIdle) && popchk_valid_i && !flush_i;
  assign push_acc = (state_q == StIdle) && push_valid_i && !popchk_valid_i && !flush_i;

  ss_stack_ram #(
    .DEPTH (DEPTH),
    .WIDTH (VLEN)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (cnt_q[AW-1:0]),
    .wdata_i (push_addr_i),
    .raddr_i (cnt_m1[AW-1:0]),
    .rdata_o (mem_top)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      top_q   <= '0;
      tgt_q   <= '0;
      code_q  <= SS_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
      tgt_q   <= tgt_d;
      code_q  <= code_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    top_d   = top_q;
    tgt_d   = tgt_q;
    code_d  = code_q;
    done_d  = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pop_acc) begin
          if (!enable_i) begin
            done_d = 1'b1;
          end else if (cnt_empty) begin
            state_d = StFault;
            code_d  = SS_UNF;
          end else begin
            // Compare happens next cycle so the address input never reaches an output.
            top_d   = mem_top;
            tgt_d   = popchk_addr_i;
            state_d = StCheck;
          end
        end else if (push_acc) begin
          if (!enable_i) begin
            done_d = 1'b1;
          end else if (cnt_full) begin
            state_d = StFault;
            code_d  = SS_OVF;
          end else begin
            mem_we = 1'b1;
            cnt_d  = cnt_p1;
            done_d = 1'b1;
          end
        end
      end
      StCheck: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (top_q == tgt_q) begin
          cnt_d   = cnt_m1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StFault;
          code_d  = SS_MISMATCH;
        end
      end
      StFault: begin
        if (ex_ack_i || flush_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ss_popchk_ex_o = '0;
    if (state_q == StFault) begin
      ss_popchk_ex_o.valid = 1'b1;
      ss_popchk_ex_o.cause = XLEN'(SS_CAUSE);
      ss_popchk_ex_o.tval  = ss_tval(code_q);
    end
    popchk_ready_o = (state_q == StIdle);
    push_ready_o   = (state_q == StIdle) && !popchk_valid_i;
    done_o         = done_q;
    count_o        = cnt_q;
  end

endmodule

// File: tb/tb_shadow_stack_unit.sv
// Self-checking bench: directed scenarios with literal expectations plus random traffic vs a queue model.
module tb_shadow_stack_unit;
  import shadow_stack_unit_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst, enable, flush, push_valid, popchk_valid, ex_ack;
  logic [VLEN-1:0] push_addr, popchk_addr;
  logic            push_ready, popchk_ready, done;
  exception_t      ex;
  logic [CW-1:0]   count;

  always #5 clk = ~clk;

  shadow_stack_unit #(
    .DEPTH    (DEPTH),
    .SS_CAUSE (18)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .flush_i        (flush),
    .push_valid_i   (push_valid),
    .push_addr_i    (push_addr),
    .push_ready_o   (push_ready),
    .popchk_valid_i (popchk_valid),
    .popchk_addr_i  (popchk_addr),
    .popchk_ready_o (popchk_ready),
    .done_o         (done),
    .ss_popchk_ex_o (ex),
    .ex_ack_i       (ex_ack),
    .count_o        (count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a queue of return addresses plus "checking" / "faulted" flags.
  logic [VLEN-1:0] m_stk[$];
  logic [VLEN-1:0] m_tgt;
  bit              m_check, m_fault, m_done, live;
  int              m_code;

  initial live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_stk.delete();
      m_check = 0;
      m_fault = 0;
      m_done  = 0;
      m_code  = 0;
    end else begin
      m_done = 0;
      if (m_fault) begin
        if (ex_ack || flush) m_fault = 0;
      end else if (m_check) begin
        m_check = 0;
        if (!flush) begin
          if (m_stk[$] == m_tgt) begin
            void'(m_stk.pop_back());
            m_done = 1;
          end else begin
            m_fault = 1;
            m_code  = 3;
          end
        end
      end else if (!flush) begin
        if (popchk_valid) begin
          if (!enable) m_done = 1;
          else if (m_stk.size() == 0) begin
            m_fault = 1;
            m_code  = 5;
          end else begin
            m_check = 1;
            m_tgt   = popchk_addr;
          end
        end else if (push_valid) begin
          if (!enable) m_done = 1;
          else if (m_stk.size() == DEPTH) begin
            m_fault = 1;
            m_code  = 4;
          end else begin
            m_stk.push_back(push_addr);
            m_done = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("done", done, m_done);
      chk("ex_valid", ex.valid, m_fault);
      chk("ex_cause", ex.cause, m_fault ? 18 : 0);
      chk("ex_tval", ex.tval, m_fault ? m_code : 0);
      chk("count", count, m_stk.size());
      chk("popchk_ready", popchk_ready, !m_fault && !m_check);
      chk("push_ready", push_ready, !m_fault && !m_check && !popchk_valid);
    end
  end

  initial begin
    rst = 1; enable = 1; flush = 0; push_valid = 0; popchk_valid = 0; ex_ack = 0;
    push_addr = '0; popchk_addr = '0;
    step();
    live = 1;
    chk("rst_count", count, 0);
    chk("rst_done", done, 0);
    chk("rst_ex", ex.valid, 0);
    rst = 0;

    // Three pushes then a matching pop-check.
    push_valid = 1; push_addr = 'h1000; step();
    chk("a_done1", done, 1); chk("a_cnt1", count, 1);
    push_addr = 'h2000; step();
    chk("a_done2", done, 1); chk("a_cnt2", count, 2);
    push_addr = 'h3000; step();
    chk("a_done3", done, 1); chk("a_cnt3", count, 3);
    push_valid = 0;
    popchk_valid = 1; popchk_addr = 'h3000; step();
    popchk_valid = 0;
    chk("a_check_nodone", done, 0);
    step();
    chk("a_pop_done", done, 1); chk("a_pop_cnt", count, 2); chk("a_nofault", ex.valid, 0);

    // Mismatch fault.
    rst = 1; step(); rst = 0;
    push_valid = 1; push_addr = 'h1000; step(); push_valid = 0;
    popchk_valid = 1; popchk_addr = 'h1004; step(); popchk_valid = 0;
    chk("b_ex_n1", ex.valid, 0);
    step();
    chk("b_ex_valid", ex.valid, 1); chk("b_cause", ex.cause, 18);
    chk("b_tval", ex.tval, 3); chk("b_cnt", count, 1);
    ex_ack = 1; step(); ex_ack = 0;
    chk("b_ex_clr", ex.valid, 0); chk("b_idle", popchk_ready, 1);

    // Overflow, then underflow.
    rst = 1; step(); rst = 0;
    push_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      push_addr = 'h100 + 4 * i; step();
    end
    push_addr = 'h999; step(); push_valid = 0;
    chk("c_ovf_valid", ex.valid, 1); chk("c_ovf_tval", ex.tval, 4); chk("c_ovf_cnt", count, 16);
    ex_ack = 1; step(); ex_ack = 0;
    rst = 1; step(); rst = 0;
    popchk_valid = 1; popchk_addr = 'h40; step(); popchk_valid = 0;
    chk("c_unf_valid", ex.valid, 1); chk("c_unf_tval", ex.tval, 5); chk("c_unf_cnt", count, 0);
    ex_ack = 1; step(); ex_ack = 0;

    // Simultaneous push and pop-check: pop-check wins, push waits.
    rst = 1; step(); rst = 0;
    push_valid = 1; push_addr = 'hA0; step();
    push_addr = 'hB0; popchk_valid = 1; popchk_addr = 'hA0; #1;
    chk("d_push_stall0", push_ready, 0);
    step(); popchk_valid = 0; #1;
    chk("d_push_stall1", push_ready, 0);
    step();
    chk("d_pop_done", done, 1); chk("d_pop_cnt", count, 0);
    step(); push_valid = 0;
    chk("d_push_done", done, 1); chk("d_final_cnt", count, 1);

    // Flush during CHECK, then reset during FAULT.
    rst = 1; step(); rst = 0;
    push_valid = 1; push_addr = 'h40; step(); push_valid = 0;
    popchk_valid = 1; popchk_addr = 'h40; step(); popchk_valid = 0;
    flush = 1; step(); flush = 0;
    chk("e_flush_done", done, 0); chk("e_flush_ex", ex.valid, 0); chk("e_flush_cnt", count, 1);
    step();
    chk("e_flush_late", done, 0);
    popchk_valid = 1; popchk_addr = 'h44; step(); popchk_valid = 0;
    step();
    chk("e_fault", ex.valid, 1);
    rst = 1; step(); rst = 0;
    chk("e_rst_ex", ex.valid, 0); chk("e_rst_tval", ex.tval, 0);
    chk("e_rst_cause", ex.cause, 0); chk("e_rst_cnt", count, 0); chk("e_rst_done", done, 0);

    // Disabled: pop-check on empty stack completes silently.
    enable = 0; popchk_valid = 1; popchk_addr = 'h80; step(); popchk_valid = 0; enable = 1;
    chk("f_done", done, 1); chk("f_noex", ex.valid, 0); chk("f_cnt", count, 0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst          = ($urandom_range(0, 199) == 0);
      enable       = ($urandom_range(0, 9) != 0);
      flush        = ($urandom_range(0, 19) == 0);
      ex_ack       = ($urandom_range(0, 2) == 0);
      push_valid   = ($urandom_range(0, 9) < 5);
      popchk_valid = ($urandom_range(0, 9) < 3);
      push_addr    = {$urandom, $urandom};
      if (m_stk.size() > 0 && $urandom_range(0, 3) != 0) popchk_addr = m_stk[$];
      else popchk_addr = {$urandom, $urandom};
      step();
    end
    rst = 0; push_valid = 0; popchk_valid = 0; flush = 0; ex_ack = 0;
    step();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
